// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared core definitions for the instruction-fetch stage.
//            - NOP_INST         : canonical bubble instruction (addi x0,x0,0)
//            - INST_BYTES       : byte stride between sequential instructions
//            - fetch_state_e    : fetch sequencer states
//            - ifid_op_e        : per-cycle action on the IF/ID register
//            - is_word_aligned  : instruction-alignment test on address bits
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD    = 2'd0,
    IFID_CAPTURE = 2'd1,
    IFID_BUBBLE  = 2'd2
  } ifid_op_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_register.sv
`default_nettype none
// ============================================================================
// Module   : pc_register
// Purpose  : Program counter with its next-PC mux. Load has priority over
//            advance; with neither asserted the PC holds. Sequential
//            advance wraps modulo 2^ADDR_WIDTH.
// Ports    : i_Clock    - clock, rising edge
//            i_Reset    - asynchronous active-high reset (PC <= RESET_ADDR)
//            i_Load     - load i_LoadAddr into the PC
//            i_Advance  - step the PC by one instruction
//            i_LoadAddr - redirect address
//            o_Pc       - current PC
// Revision : 1.0 - initial release
// ============================================================================
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Load,
  input  logic                  i_Advance,
  input  logic [ADDR_WIDTH-1:0] i_LoadAddr,
  output logic [ADDR_WIDTH-1:0] o_Pc
);

  localparam logic [ADDR_WIDTH-1:0] c_PC_STEP = ADDR_WIDTH'(INST_BYTES);

  logic [ADDR_WIDTH-1:0] r_Pc;
  logic [ADDR_WIDTH-1:0] w_PcNext;

  always_comb begin
    w_PcNext = r_Pc;
    if (i_Load) begin
      w_PcNext = i_LoadAddr;
    end else if (i_Advance) begin
      // Natural overflow of the adder gives the silent wrap to 0.
      w_PcNext = r_Pc + c_PC_STEP;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Pc <= RESET_ADDR;
    end else begin
      r_Pc <= w_PcNext;
    end
  end

  assign o_Pc = r_Pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Single-cycle instruction fetch from a combinational instruction
//            memory into the IF/ID pipeline register. A START cycle follows
//            reset, then RUN fetches sequentially, honouring stall, flush
//            and branch redirect. A branch to a non-word-aligned target
//            raises a sticky fault and parks the stage in HALT until reset.
// Ports    : i_Clock        - clock, rising edge
//            i_Reset        - asynchronous active-high reset
//            o_MemAddr      - instruction memory address (= PC)
//            i_MemData      - instruction word at o_MemAddr, same cycle
//            i_Stall        - hold PC and IF/ID
//            i_Flush        - replace IF/ID contents with a bubble
//            i_BranchTaken  - redirect PC to i_BranchTarget
//            i_BranchTarget - redirect address
//            o_Inst         - IF/ID instruction
//            o_PC           - IF/ID PC of o_Inst
//            o_Valid        - o_Inst/o_PC hold a real instruction
//            o_Fault        - sticky misaligned-branch-target fault
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  input  logic [DATA_WIDTH-1:0] i_MemData,
  input  logic                  i_Stall,
  input  logic                  i_Flush,
  input  logic                  i_BranchTaken,
  input  logic [ADDR_WIDTH-1:0] i_BranchTarget,
  output logic [DATA_WIDTH-1:0] o_Inst,
  output logic [ADDR_WIDTH-1:0] o_PC,
  output logic                  o_Valid,
  output logic                  o_Fault
);

  localparam logic [DATA_WIDTH-1:0] c_NOP = DATA_WIDTH'(NOP_INST);

  fetch_state_e          r_State;
  fetch_state_e          w_StateNext;
  ifid_op_e              w_IfidOp;
  logic                  w_PcLoad;
  logic                  w_PcAdvance;
  logic                  w_SetFault;
  logic [ADDR_WIDTH-1:0] w_Pc;

  logic [DATA_WIDTH-1:0] r_Inst;
  logic [ADDR_WIDTH-1:0] r_IfPc;
  logic                  r_Valid;
  logic                  r_Fault;

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  pc_register #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_register (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Load     (w_PcLoad),
    .i_Advance  (w_PcAdvance),
    .i_LoadAddr (i_BranchTarget),
    .o_Pc       (w_Pc)
  );

  assign o_MemAddr = w_Pc;

  // --------------------------------------------------------------------------
  // Fetch sequencer: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= ST_START;
    end else begin
      r_State <= w_StateNext;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch sequencer: next state and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_StateNext = r_State;
    w_PcLoad    = 1'b0;
    w_PcAdvance = 1'b0;
    w_SetFault  = 1'b0;
    w_IfidOp    = IFID_HOLD;

    case (r_State)
      // One idle cycle after reset; inputs are not acted upon here.
      ST_START: begin
        w_StateNext = ST_RUN;
      end

      ST_RUN: begin
        if (i_BranchTaken) begin
          // Branch overrides stall; the wrong-path word is never captured.
          w_IfidOp = IFID_BUBBLE;
          if (is_word_aligned(i_BranchTarget[1:0])) begin
            w_PcLoad = 1'b1;
          end else begin
            w_SetFault  = 1'b1;
            w_StateNext = ST_HALT;
          end
        end else begin
          w_PcAdvance = !i_Stall;
          if (i_Flush) begin
            w_IfidOp = IFID_BUBBLE;
          end else if (!i_Stall) begin
            w_IfidOp = IFID_CAPTURE;
          end
        end
      end

      // Keep re-asserting the bubble so IF/ID stays empty while parked.
      ST_HALT: begin
        w_IfidOp = IFID_BUBBLE;
      end

      // Unreachable encoding: park safely rather than fetch garbage.
      default: begin
        w_StateNext = ST_HALT;
        w_IfidOp    = IFID_BUBBLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // IF/ID pipeline register. o_PC is left untouched by a bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Inst  <= c_NOP;
      r_IfPc  <= '0;
      r_Valid <= 1'b0;
    end else begin
      case (w_IfidOp)
        IFID_CAPTURE: begin
          r_Inst  <= i_MemData;
          r_IfPc  <= w_Pc;
          r_Valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          r_Inst  <= c_NOP;
          r_Valid <= 1'b0;
        end
        default: begin
          r_Inst  <= r_Inst;
          r_IfPc  <= r_IfPc;
          r_Valid <= r_Valid;
        end
      endcase
    end
  end

  // Sticky until reset.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Fault <= 1'b0;
    end else if (w_SetFault) begin
      r_Fault <= 1'b1;
    end
  end

  assign o_Inst  = r_Inst;
  assign o_PC    = r_IfPc;
  assign o_Valid = r_Valid;
  assign o_Fault = r_Fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A 16-bit-address instance
//            is compared every cycle against a behavioural model; an 8-bit
//            instance sharing the same stimulus exercises PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, br;
  logic [15:0] tgt;

  logic [31:0] mem [0:63];

  logic [15:0] addr16, pc16;
  logic [31:0] inst16, data16;
  logic        valid16, fault16;

  logic [7:0]  addr8, pc8;
  logic [31:0] inst8, data8;
  logic        valid8, fault8;

  assign data16 = mem[addr16[7:2]];
  assign data8  = mem[addr8[7:2]];

  always #5 clk = ~clk;

  fetch_stage #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .RESET_ADDR (16'h0000)
  ) u_dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .o_MemAddr      (addr16),
    .i_MemData      (data16),
    .i_Stall        (stall),
    .i_Flush        (flush),
    .i_BranchTaken  (br),
    .i_BranchTarget (tgt),
    .o_Inst         (inst16),
    .o_PC           (pc16),
    .o_Valid        (valid16),
    .o_Fault        (fault16)
  );

  fetch_stage #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (8),
    .RESET_ADDR (8'h00)
  ) u_dut8 (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .o_MemAddr      (addr8),
    .i_MemData      (data8),
    .i_Stall        (stall),
    .i_Flush        (flush),
    .i_BranchTaken  (br),
    .i_BranchTarget (tgt[7:0]),
    .o_Inst         (inst8),
    .o_PC           (pc8),
    .o_Valid        (valid8),
    .o_Fault        (fault8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the 16-bit instance
  int          m_pc;
  int          m_opc;
  bit          m_run;
  bit          m_halt;
  bit          m_valid;
  bit          m_fault;
  logic [31:0] m_inst;
  int          halt_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 0;
    m_opc    = 0;
    m_run    = 1'b0;
    m_halt   = 1'b0;
    m_valid  = 1'b0;
    m_fault  = 1'b0;
    m_inst   = c_NOP;
    halt_cnt = 0;
  endtask

  // Effect of one rising edge, computed from the fetch rules directly.
  task automatic model_edge(input bit s, input bit f, input bit b, input int t);
    logic [31:0] word;
    word = mem[(m_pc >> 2) & 63];
    if (m_halt) begin
      // parked: nothing changes
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (b) begin
      m_inst  = c_NOP;
      m_valid = 1'b0;
      if ((t % 4) != 0) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
      end else begin
        m_pc = t;
      end
    end else begin
      if (f) begin
        m_inst  = c_NOP;
        m_valid = 1'b0;
      end else if (!s) begin
        m_inst  = word;
        m_opc   = m_pc;
        m_valid = 1'b1;
      end
      if (!s) m_pc = (m_pc + 4) % 65536;
    end
  endtask

  // Apply inputs for one cycle, clock it, then compare against the model.
  task automatic step(input bit s, input bit f, input bit b, input logic [15:0] t);
    stall = s;
    flush = f;
    br    = b;
    tgt   = t;
    model_edge(s, f, b, int'(t));
    @(posedge clk);
    #1;
    check_eq("memaddr", addr16, m_pc);
    check_eq("valid",   valid16, m_valid);
    check_eq("fault",   fault16, m_fault);
    check_eq("inst",    inst16, m_inst);
    if (m_valid) check_eq("ifpc", pc16, m_opc);
    if (m_halt) halt_cnt++;
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_memaddr", addr16, 0);
    check_eq("rst_inst",    inst16, c_NOP);
    check_eq("rst_ifpc",    pc16, 0);
    check_eq("rst_valid",   valid16, 0);
    check_eq("rst_fault",   fault16, 0);
    check_eq("rst_memaddr8", addr8, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    br    = 1'b0;
    tgt   = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    model_reset();

    @(posedge clk);
    #1;
    do_reset();

    // START cycle, then first two fetches
    step(0, 0, 0, 16'h0);
    check_eq("start_valid", valid16, 0);
    step(0, 0, 0, 16'h0);
    check_eq("first_inst", inst16, 32'h11);
    check_eq("first_pc",   pc16, 16'h0);
    check_eq("first_vld",  valid16, 1);
    step(0, 0, 0, 16'h0);
    check_eq("second_inst", inst16, 32'h22);
    check_eq("second_pc",   pc16, 16'h4);

    // Three-cycle stall at PC 0x8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 16'h0);
      check_eq("stall_addr", addr16, 16'h8);
      check_eq("stall_inst", inst16, 32'h22);
      check_eq("stall_pc",   pc16, 16'h4);
      check_eq("stall_vld",  valid16, 1);
    end
    step(0, 0, 0, 16'h0);
    check_eq("resume_inst", inst16, mem[2]);
    check_eq("resume_pc",   pc16, 16'h8);

    // Lone flush: bubble, PC still advances (0xC -> 0x10)
    step(0, 1, 0, 16'h0);
    check_eq("flush_vld",  valid16, 0);
    check_eq("flush_inst", inst16, c_NOP);
    check_eq("flush_addr", addr16, 16'h10);

    // Branch while stalled
    step(1, 0, 1, 16'h0100);
    check_eq("br_addr", addr16, 16'h0100);
    check_eq("br_vld",  valid16, 0);
    step(0, 0, 0, 16'h0);
    check_eq("br_pc",   pc16, 16'h0100);
    check_eq("br_inst", inst16, 32'h11);

    // Wrap-around on the 8-bit instance
    do_reset();
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h00FC);
    check_eq("wrap_pre8", addr8, 8'hFC);
    step(0, 0, 0, 16'h0);
    check_eq("wrap_addr8", addr8, 8'h00);
    check_eq("wrap_pc8",   pc8, 8'hFC);

    // Misaligned target: sticky fault, HALT ignores inputs
    step(0, 0, 1, 16'h0102);
    for (int i = 0; i < 11; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 65535)));
      check_eq("halt_fault", fault16, 1);
      check_eq("halt_vld",   valid16, 0);
      check_eq("halt_addr",  addr16, 16'h0100);
    end
    stall = 1'b1;
    do_reset();
    check_eq("post_halt_fault", fault16, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if (m_halt && halt_cnt >= 12) do_reset();
      else if ($urandom_range(0, 99) == 0) do_reset();
      begin
        bit          s, f, b;
        logic [15:0] t;
        s = ($urandom_range(0, 3) == 0);
        f = ($urandom_range(0, 6) == 0);
        b = ($urandom_range(0, 9) == 0);
        t = 16'($urandom_range(0, 65535)) & 16'hFFFC;
        if ($urandom_range(0, 7) == 0) t = t | 16'($urandom_range(1, 3));
        step(s, f, b, t);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, program-counter and memory address width.
REQ-003 SHALL have parameter RESET_ADDR, default 0, PC value after reset.
REQ-004 SHALL have port i_Clock, input, 1, single clock, all state updates on rising edge.
REQ-005 SHALL have port i_Reset, input, 1, reset (asynchronous, active-high).
REQ-006 SHALL have port o_MemAddr, output, ADDR_WIDTH, address to the combinational instruction memory.
REQ-007 SHALL have port i_MemData, input, DATA_WIDTH, instruction word returned for o_MemAddr in the same cycle.
REQ-008 SHALL have port i_Stall, input, 1, hold PC and IF/ID register.
REQ-009 SHALL have port i_Flush, input, 1, kill the IF/ID register contents (insert bubble).
REQ-010 SHALL have port i_BranchTaken, input, 1, redirect PC to i_BranchTarget.
REQ-011 SHALL have port i_BranchTarget, input, ADDR_WIDTH, redirect address.
REQ-012 SHALL have port o_Inst, output, DATA_WIDTH, registered instruction to decode.
REQ-013 SHALL have port o_PC, output, ADDR_WIDTH, registered PC of o_Inst.
REQ-014 SHALL have port o_Valid, output, 1, o_Inst/o_PC hold a real instruction.
REQ-015 SHALL have port o_Fault, output, 1, sticky misaligned-target fault.

Function
REQ-016 SHALL drive o_MemAddr combinationally from the PC register.
REQ-017 SHALL implement states START, RUN, HALT. START is entered on reset and lasts exactly one cycle, then moves to RUN unconditionally; o_Valid is not set from START.
REQ-018 In RUN with i_Stall=0 and i_BranchTaken=0, SHALL load PC <= PC+4, modulo 2^ADDR_WIDTH (wraps to 0 with no flag).
REQ-019 In RUN with i_BranchTaken=1 and i_BranchTarget[1:0]=0, SHALL load PC <= i_BranchTarget regardless of i_Stall.
REQ-020 In RUN with i_BranchTaken=1 and i_BranchTarget[1:0]!=0, SHALL hold PC, set o_Fault=1 and go to HALT next cycle.
REQ-021 In RUN with i_Stall=1 and i_BranchTaken=0, SHALL hold PC.
REQ-022 In RUN, when not stalled, not flushed and not branching, SHALL capture o_Inst<=i_MemData, o_PC<=PC, o_Valid<=1.
REQ-023 When i_Flush=1 or i_BranchTaken=1, SHALL load the IF/ID register with o_Inst<=NOP_INST, o_Valid<=0 (o_PC don't-care, held). Flush has priority over stall.
REQ-024 When i_Stall=1 and no flush/branch, SHALL hold o_Inst, o_PC and o_Valid unchanged.
REQ-025 In HALT, SHALL hold PC, keep o_Valid=0 and o_Inst=NOP_INST, and ignore all inputs until reset.
REQ-026 Fetch-to-decode latency SHALL be one cycle: the word at PC appears on o_Inst the cycle after PC is presented.

Reset
REQ-027 Asserting i_Reset SHALL immediately (asynchronously) set PC=RESET_ADDR, state=START, o_Inst=NOP_INST, o_PC=0, o_Valid=0, o_Fault=0. This applies also when reset is asserted mid-stall or during HALT.
REQ-028 The first valid instruction SHALL appear on o_Inst two cycles after i_Reset deasserts (one START cycle plus one fetch cycle).

Structure
REQ-029 NOP_INST (32'h00000013) and the fetch-state enum typedef SHALL live in the shared core package.
REQ-030 The PC register with its next-PC mux SHALL be a sub-module pc_register; the state machine and IF/ID register SHALL remain in fetch_stage.

Verification
REQ-031 Reset release with RESET_ADDR=0 and memory words 0x11,0x22 at 0x0,0x4: o_Inst=0x11,o_PC=0 and then 0x22,0x4 on consecutive cycles, each with o_Valid=1.
REQ-032 i_Stall high for 3 cycles at PC=0x8: o_MemAddr stays 0x8 and o_Inst/o_PC/o_Valid are frozen; fetch resumes at 0x8 afterwards.
REQ-033 i_BranchTaken with target 0x100 while i_Stall=1: next o_MemAddr=0x100, next o_Valid=0, and the cycle after that o_PC=0x100.
REQ-034 i_BranchTaken with target 0x102: o_Fault=1 and o_Valid=0 persist for 10+ cycles; i_Reset clears both and PC=RESET_ADDR.
REQ-035 PC=2^ADDR_WIDTH-4 (ADDR_WIDTH=8, PC=0xFC) with no stall: next o_MemAddr=0x00.
REQ-036 i_Flush pulsed alone for one cycle: o_Valid=0 and o_Inst=0x13 for that cycle; PC still advances by 4.
